arb_requester: RTL

- Requester-side agent for the two-way req/gnt arbiter. One instance drives one arbiter req input and consumes the matching gnt output.
- Accepts a burst command (start data, length) over a valid/ready port and raises req. It then emits one data beat per cycle in which gnt is high, until the burst completes.
- Tolerates preemption: the arbiter may drop gnt mid-burst. The requester then holds req and resumes at the next unsent beat.
- Sits between a local command source and the shared arbitrated bus.

---
 rtl/arb_req_pkg.sv | 19 +
 rtl/arb_req_timer.sv | 50 +++++
 rtl/arb_requester.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/arb_req_pkg.sv
// -----------------------------------------------------------------------------
// arb_req_pkg
//   Shared types and default widths for the arbiter requester agent.
//   - arb_req_state_e : requester FSM state encoding (IDLE, REQ, XFER).
//   - ARB_REQ_DATA_W  : default beat data width.
//   - ARB_REQ_LEN_W   : default burst length field width (beats minus one).
// -----------------------------------------------------------------------------
package arb_req_pkg;

    localparam int ARB_REQ_DATA_W = 8;
    localparam int ARB_REQ_LEN_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2
    } arb_req_state_e;

endpackage

// File: rtl/arb_req_timer.sv
// -----------------------------------------------------------------------------
// arb_req_timer
//   Saturating count of consecutive no-grant cycles spent waiting in REQ.
//   Only instantiated when ARB_REQ_TIMEOUT_EN is defined.
//
// Ports:
//   clk    in   clock, rising edge
//   rst    in   asynchronous active-low reset
//   clr    in   restart the count (command accepted or beat transferred)
//   inc    in   one more no-grant cycle; saturates at WAIT_MAX
//   expire out  count has reached WAIT_MAX-1, so this no-grant cycle is the
//               last one tolerated
// -----------------------------------------------------------------------------
module arb_req_timer
    import arb_req_pkg::*;
#(
    parameter int WAIT_MAX = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expire
);

    localparam int CNT_W = $clog2(WAIT_MAX + 1);

    logic [CNT_W-1:0] wait_cnt_q;
    logic [CNT_W-1:0] wait_cnt_d;

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (clr) begin
            wait_cnt_d = '0;
        end else if (inc && (wait_cnt_q != CNT_W'(WAIT_MAX))) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
    end

    assign expire = (wait_cnt_q == CNT_W'(WAIT_MAX - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

endmodule

// File: rtl/arb_requester.sv
// -----------------------------------------------------------------------------
// arb_requester
//   Requester-side agent for the two-way req/gnt arbiter. Takes a burst
//   command (start data, length) and raises req; every cycle in which gnt is
//   high while a burst is pending transfers one beat whose data is the start
//   value plus the beat index. If the arbiter drops gnt mid-burst, req stays
//   up and the burst resumes at the next unsent beat.
//
//   Optional feature (macro ARB_REQ_TIMEOUT_EN): abort a burst after WAIT_MAX
//   consecutive no-grant cycles in REQ and raise the sticky timeout_err,
//   which is cleared by the next accepted command. Without the macro the
//   requester waits indefinitely and timeout_err is tied low.
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   asynchronous active-low reset
//   cmd_valid    in   command offered
//   cmd_ready    out  high in IDLE; command accepted on cmd_valid&&cmd_ready
//   cmd_data     in   data of beat 0
//   cmd_len      in   burst length minus one
//   req          out  registered request to the arbiter
//   gnt          in   grant from the arbiter
//   bus_valid    out  a beat transfers this cycle (combinational on gnt)
//   bus_data     out  beat data
//   bus_last     out  final beat of the burst, qualified by bus_valid
//   busy         out  FSM not in IDLE
//   timeout_err  out  sticky abort flag
// -----------------------------------------------------------------------------
module arb_requester
    import arb_req_pkg::*;
#(
    parameter int DATA_W   = ARB_REQ_DATA_W,
    parameter int LEN_W    = ARB_REQ_LEN_W,
    parameter int WAIT_MAX = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic              req,
    input  logic              gnt,
    output logic              bus_valid,
    output logic [DATA_W-1:0] bus_data,
    output logic              bus_last,
    output logic              busy,
    output logic              timeout_err
);

    if (WAIT_MAX < 1) begin : g_bad_wait_max
        $error("arb_requester: WAIT_MAX must be >= 1");
    end

    arb_req_state_e    state_q;
    arb_req_state_e    state_d;
    logic              req_q;
    logic              req_d;
    logic [LEN_W-1:0]  beat_cnt_q;
    logic [LEN_W-1:0]  beat_cnt_d;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  len_d;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;

    logic in_burst;
    logic fire;
    logic last_beat;

`ifdef ARB_REQ_TIMEOUT_EN
    logic timer_clr;
    logic timer_inc;
    logic timer_expire;
    logic timeout_err_q;
    logic timeout_err_d;
`endif

    // A grant only counts while a burst is pending; a grant still high in
    // the first IDLE cycle after the last beat is not a beat.
    assign in_burst  = (state_q == REQ) || (state_q == XFER);
    assign fire      = in_burst && gnt;
    assign last_beat = (beat_cnt_q == len_q);

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign req       = req_q;
    assign bus_valid = fire;
    assign bus_last  = fire && last_beat;
    assign bus_data  = data_q + DATA_W'(beat_cnt_q);

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        beat_cnt_d = beat_cnt_q;
        data_d     = data_q;
        len_d      = len_q;
`ifdef ARB_REQ_TIMEOUT_EN
        timer_clr     = 1'b0;
        timer_inc     = 1'b0;
        timeout_err_d = timeout_err_q;
`endif
        case (state_q)
            IDLE: begin
                req_d = 1'b0;
                if (cmd_valid) begin
                    data_d     = cmd_data;
                    len_d      = cmd_len;
                    beat_cnt_d = '0;
                    state_d    = REQ;
                    req_d      = 1'b1;
`ifdef ARB_REQ_TIMEOUT_EN
                    timer_clr     = 1'b1;
                    timeout_err_d = 1'b0;
`endif
                end
            end
            REQ, XFER: begin
                req_d = 1'b1;
                if (gnt) begin
                    if (last_beat) begin
                        state_d = IDLE;
                        req_d   = 1'b0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + LEN_W'(1);
                        state_d    = XFER;
`ifdef ARB_REQ_TIMEOUT_EN
                        timer_clr = 1'b1;
`endif
                    end
                end else if (state_q == XFER) begin
                    // Preempted: keep req up and hold beat_cnt so the next
                    // grant resumes at the first unsent beat.
                    state_d = REQ;
`ifdef ARB_REQ_TIMEOUT_EN
                end else begin
                    if (timer_expire) begin
                        state_d       = IDLE;
                        req_d         = 1'b0;
                        timeout_err_d = 1'b1;
                    end else begin
                        timer_inc = 1'b1;
                    end
`endif
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            req_q      <= 1'b0;
            beat_cnt_q <= '0;
            data_q     <= '0;
            len_q      <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            beat_cnt_q <= beat_cnt_d;
            data_q     <= data_d;
            len_q      <= len_d;
        end
    end

`ifdef ARB_REQ_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timeout_err_q <= 1'b0;
        end else begin
            timeout_err_q <= timeout_err_d;
        end
    end

    arb_req_timer #(
        .WAIT_MAX (WAIT_MAX)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (timer_clr),
        .inc    (timer_inc),
        .expire (timer_expire)
    );

    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule
